mem_stage: RTL and testbench
============================

# mem_stage

Pipeline MEM stage: holds the EX/MEM segment register, runs the data-memory request/acknowledge handshake, aligns and extends load data, and holds the MEM/WB segment register. It is the producer of the MEM- and WB-stage writeback triples (`rf_we_*`, `rf_wa_*`, `rf_wd_*`) consumed by the EX-stage operand forwarding logic and the register file. While a memory access is outstanding it freezes IF through EX via `mem_stall`.

## Interface
- No parameters; data path 32 bits, register address 5 bits.
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds a real instruction (0 = bubble/flushed).
- `ex_rf_we`, `ex_rf_wa` in 1, 5: destination write enable and address.
- `ex_alu_res` in 32: ALU result / memory address.
- `ex_mem_re`, `ex_mem_we` in 1, 1: load, store (mutually exclusive).
- `ex_mem_size` in 2: 00 byte, 01 half, 10 word.
- `ex_mem_sext` in 1: sign-extend load (1) or zero-extend (0).
- `ex_mem_wd` in 32: store data, right-aligned.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: access is a store.
- `dmem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata` out 32: store data lane-replicated.
- `dmem_wstrb` out 4: byte strobes.
- `dmem_ack` in 1: access complete this cycle.
- `dmem_rdata` in 32: read word, valid with `dmem_ack`.
- `mem_stall` out 1: freeze IF/ID/EX and the EX/MEM capture.
- `mem_misalign` out 1: instruction in MEM is a misaligned access.
- `rf_we_mem`, `rf_wa_mem`, `rf_wd_mem` out 1, 5, 32: MEM-stage writeback triple.
- `rf_we_wb`, `rf_wa_wb`, `rf_wd_wb` out 1, 5, 32: WB-stage triple, drives register file write port.

## Operation
- EX/MEM register captures all `ex_*` at each edge when `mem_stall`=0; holds when 1. `ex_valid`=0 captures a bubble (valid=0).
- FSM states IDLE, WAIT, DONE; reset to IDLE.
  - Any state, on capture (`mem_stall`=0) of a valid, aligned load/store: next WAIT; other capture: next IDLE.
  - WAIT: `dmem_req`=1, `mem_stall`=1. On `dmem_ack`: latch aligned load data, next DONE. Else stay.
  - DONE: `mem_stall`=0; instruction leaves at this edge; next per capture rule.
- `dmem_req` = (state==WAIT); `dmem_we` = registered store flag.
- Misalign: half with addr[0]=1, word with addr[1:0]!=0. No request issued, FSM stays IDLE, `mem_misalign`=1 while held, no register write.
- Store strobes: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111. `dmem_wdata`: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Load: rdata >> (a[1:0]*8), take 8/16/32 bits, sign- or zero-extend per `ex_mem_sext`.
- `rf_wd_mem` = load ? latched load data : alu_res.
- `rf_we_mem` = valid & rf_we & !misalign & (rf_wa!=0) & (!load | state==DONE). Writes to r0 never appear on either triple.
- MEM/WB register: when `mem_stall`=0 capture MEM triple; when `mem_stall`=1 capture bubble (`rf_we_wb`=0), since WB instruction retires every cycle.

## Timing
- Reset: all outputs 0, FSM IDLE, both segment registers empty. Assert mid-WAIT: `dmem_req` drops immediately; late `dmem_ack` after release is ignored (IDLE).
- Non-memory instruction: 1 cycle in MEM; WB triple valid the next cycle.
- Load/store with ack in first WAIT cycle: 2 cycles in MEM (WAIT, DONE); each extra ack wait adds 1.
- `rf_we_mem` for a load is 0 during WAIT, 1 only in DONE.
- `dmem_req` held continuously until `dmem_ack`; `dmem_addr/we/wdata/wstrb` stable during WAIT.
- Back-to-back memory ops: DONE of first and WAIT entry of second occur at the same edge, no idle cycle.

## Test plan
- ALU op `ex_rf_wa`=5, alu_res=0x1234 -> next cycle `rf_we_mem`=1,`rf_wd_mem`=0x1234; following cycle same on WB triple.
- LB addr 0x103, sext=1, rdata 0x80FF_FF00, ack after 3 cycles -> `mem_stall` 3 cycles, `rf_wd_mem`=0xFFFF_FF80 in DONE only.
- SH addr 0x102, wd=0xABCD -> `dmem_wstrb`=1100, `dmem_wdata`=0xABCD_ABCD, `dmem_addr`=0x100, `rf_we_*`=0.
- LW addr 0x101 -> `mem_misalign`=1, `dmem_req` never 1, no stall, `rf_we_mem`=0.
- ALU op with wa=0 -> `rf_we_mem`=0 and `rf_we_wb`=0.
- `rstn` low during WAIT -> `dmem_req`=0 immediately; after release ack pulse ignored, all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage.
// Holds the EX/MEM segment register, runs the data-memory req/ack handshake,
// aligns and extends load data, and holds the MEM/WB segment register.
// While an access is outstanding, mem_stall freezes IF through EX.
module mem_stage (
  input  logic        clk,
  input  logic        rstn,
  // EX-stage instruction
  input  logic        ex_valid,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_wa,
  input  logic [31:0] ex_alu_res,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_sext,
  input  logic [31:0] ex_mem_wd,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // pipeline control
  output logic        mem_stall,
  output logic        mem_misalign,
  // MEM-stage writeback triple (forwarding source)
  output logic        rf_we_mem,
  output logic [4:0]  rf_wa_mem,
  output logic [31:0] rf_wd_mem,
  // WB-stage triple (register file write port)
  output logic        rf_we_wb,
  output logic [4:0]  rf_wa_wb,
  output logic [31:0] rf_wd_wb
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // A half must be 2-byte aligned, a word (or reserved size) 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic r;
    r = 1'b0;
    case (size)
      SIZE_BYTE: r = 1'b0;
      SIZE_HALF: r = low[0];
      default:   r = (low != 2'b00);
    endcase
    return r;
  endfunction

  // EX/MEM segment register contents
  logic        valid_reg;
  logic        rf_we_reg;
  logic [4:0]  rf_wa_reg;
  logic [31:0] alu_res_reg;
  logic        mem_re_reg;
  logic        mem_we_reg;
  logic [1:0]  size_reg;
  logic        sext_reg;
  logic [31:0] wd_reg;

  // handshake state and latched load result
  state_t      state_reg;
  state_t      state_next;
  logic [31:0] load_data_reg;

  // MEM/WB segment register
  logic        wb_we_reg;
  logic [4:0]  wb_wa_reg;
  logic [31:0] wb_wd_reg;

  logic        ex_access;
  logic        misalign_now;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_wdata;
  logic [3:0]  strobe_raw;
  logic        we_mem_now;

  // The incoming instruction starts a bus access only if it is real and aligned.
  assign ex_access = ex_valid & (ex_mem_re | ex_mem_we)
                   & ~is_misaligned(ex_mem_size, ex_alu_res[1:0]);

  assign misalign_now = valid_reg & (mem_re_reg | mem_we_reg)
                      & is_misaligned(size_reg, alu_res_reg[1:0]);

  // EX/MEM capture: advance when not stalled; a bubble clears all control flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg   <= 1'b0;
      rf_we_reg   <= 1'b0;
      rf_wa_reg   <= 5'd0;
      alu_res_reg <= 32'd0;
      mem_re_reg  <= 1'b0;
      mem_we_reg  <= 1'b0;
      size_reg    <= 2'b00;
      sext_reg    <= 1'b0;
      wd_reg      <= 32'd0;
    end else if (!mem_stall) begin
      valid_reg   <= ex_valid;
      rf_we_reg   <= ex_valid & ex_rf_we;
      rf_wa_reg   <= ex_rf_wa;
      alu_res_reg <= ex_alu_res;
      mem_re_reg  <= ex_valid & ex_mem_re;
      mem_we_reg  <= ex_valid & ex_mem_we;
      size_reg    <= ex_mem_size;
      sext_reg    <= ex_mem_sext;
      wd_reg      <= ex_mem_wd;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs: WAIT holds the request until ack; from
  // any other state the next capture decides whether a new access starts.
  always_comb begin
    state_next = state_reg;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    case (state_reg)
      ST_WAIT: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ack) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ex_access ? ST_WAIT : ST_IDLE;
      end
    endcase
  end

  assign dmem_we   = mem_we_reg;
  assign dmem_addr = {alu_res_reg[31:2], 2'b00};

  // Store lane replication: each byte lane takes the byte of the store datum
  // that lands on it for the access width.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (size_reg)
          SIZE_BYTE: lane_wdata[gi*8 +: 8] = wd_reg[7:0];
          SIZE_HALF: lane_wdata[gi*8 +: 8] = wd_reg[(gi % 2)*8 +: 8];
          default:   lane_wdata[gi*8 +: 8] = wd_reg[gi*8 +: 8];
        endcase
      end
    end
  endgenerate

  assign dmem_wdata = lane_wdata;

  // Byte strobes for the addressed lanes; loads drive no strobes.
  always_comb begin
    strobe_raw = 4'b1111;
    case (size_reg)
      SIZE_BYTE: strobe_raw = 4'b0001 << alu_res_reg[1:0];
      SIZE_HALF: strobe_raw = 4'b0011 << {alu_res_reg[1], 1'b0};
      default:   strobe_raw = 4'b1111;
    endcase
  end

  assign dmem_wstrb = mem_we_reg ? strobe_raw : 4'b0000;

  // Load alignment: bring the addressed byte/half down to bit 0, then extend.
  assign rdata_shifted = dmem_rdata >> {alu_res_reg[1:0], 3'b000};

  // Sign or zero extension of the aligned load datum.
  always_comb begin
    load_ext = rdata_shifted;
    case (size_reg)
      SIZE_BYTE: load_ext = {{24{sext_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_HALF: load_ext = {{16{sext_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:   load_ext = rdata_shifted;
    endcase
  end

  // Latch the load result on the acknowledging cycle so it survives into DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_data_reg <= 32'd0;
    end else if (state_reg == ST_WAIT && dmem_ack) begin
      load_data_reg <= load_ext;
    end
  end

  // A load only has its result in DONE; r0 writes are suppressed here so
  // neither triple ever advertises them.
  assign we_mem_now = valid_reg & rf_we_reg & ~misalign_now & (rf_wa_reg != 5'd0)
                    & (~mem_re_reg | (state_reg == ST_DONE));

  assign rf_we_mem    = we_mem_now;
  assign rf_wa_mem    = rf_wa_reg;
  assign rf_wd_mem    = mem_re_reg ? load_data_reg : alu_res_reg;
  assign mem_misalign = misalign_now;

  // MEM/WB capture: WB retires every cycle, so a stalled MEM feeds it a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_we_reg <= 1'b0;
      wb_wa_reg <= 5'd0;
      wb_wd_reg <= 32'd0;
    end else if (mem_stall) begin
      wb_we_reg <= 1'b0;
      wb_wa_reg <= 5'd0;
      wb_wd_reg <= 32'd0;
    end else begin
      wb_we_reg <= we_mem_now;
      wb_wa_reg <= rf_wa_reg;
      wb_wd_reg <= rf_wd_mem;
    end
  end

  assign rf_we_wb = wb_we_reg;
  assign rf_wa_wb = wb_wa_reg;
  assign rf_wd_wb = wb_wd_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus, transaction-level model and per-cycle compare.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_rf_we, ex_mem_re, ex_mem_we, ex_mem_sext;
  logic [4:0]  ex_rf_wa;
  logic [31:0] ex_alu_res, ex_mem_wd;
  logic [1:0]  ex_mem_size;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, mem_misalign;
  logic        rf_we_mem, rf_we_wb;
  logic [4:0]  rf_wa_mem, rf_wa_wb;
  logic [31:0] rf_wd_mem, rf_wd_wb;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_rf_wa(ex_rf_wa),
    .ex_alu_res(ex_alu_res), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_mem_size(ex_mem_size), .ex_mem_sext(ex_mem_sext), .ex_mem_wd(ex_mem_wd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .rf_we_mem(rf_we_mem), .rf_wa_mem(rf_wa_mem), .rf_wd_mem(rf_wd_mem),
    .rf_we_wb(rf_we_wb), .rf_wa_wb(rf_wa_wb), .rf_wd_wb(rf_wd_wb)
  );

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic        re;
    logic        mwe;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wd;
  } instr_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misal(input instr_t i);
    return i.valid && (i.re || i.mwe) && ((int'(i.alu[1:0]) % nbytes(i.size)) != 0);
  endfunction

  function automatic logic [3:0] strobe(input instr_t i);
    int n, start;
    logic [3:0] s;
    n = nbytes(i.size);
    start = (int'(i.alu[1:0]) / n) * n;
    s = 4'b0000;
    for (int k = 0; k < n; k++) s[start + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] lanes(input instr_t i);
    int n;
    logic [31:0] r;
    n = nbytes(i.size);
    r = 32'd0;
    for (int lane = 0; lane < 4; lane++) r[lane*8 +: 8] = i.wd[(lane % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_val(input instr_t i, input logic [31:0] rdata);
    int n;
    logic [31:0] v, mask;
    n = nbytes(i.size);
    v = rdata >> (8 * int'(i.alu[1:0]));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (i.sext && v[8*n - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  instr_t      m_ins;
  bit          m_wait, m_done;
  logic [31:0] m_ld;
  logic        m_wb_we;
  logic [4:0]  m_wb_wa;
  logic [31:0] m_wb_wd;

  function automatic logic exp_we_mem();
    return m_ins.valid && m_ins.we && !misal(m_ins) && (m_ins.wa != 5'd0) && (!m_ins.re || m_done);
  endfunction

  function automatic logic [31:0] exp_wd_mem();
    return m_ins.re ? m_ld : m_ins.alu;
  endfunction

  // Model advance: an instruction sits in MEM until its access (if any) is acked.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ins = '0; m_wait = 0; m_done = 0; m_ld = 32'd0;
      m_wb_we = 1'b0; m_wb_wa = 5'd0; m_wb_wd = 32'd0;
    end else if (m_wait) begin
      m_wb_we = 1'b0; m_wb_wa = 5'd0; m_wb_wd = 32'd0;
      if (dmem_ack) begin
        m_ld = load_val(m_ins, dmem_rdata);
        m_wait = 0;
        m_done = 1;
      end
    end else begin
      m_wb_we = exp_we_mem();
      m_wb_wa = m_ins.wa;
      m_wb_wd = exp_wd_mem();
      if (ex_valid)
        m_ins = '{valid: 1'b1, we: ex_rf_we, wa: ex_rf_wa, alu: ex_alu_res, re: ex_mem_re,
                  mwe: ex_mem_we, size: ex_mem_size, sext: ex_mem_sext, wd: ex_mem_wd};
      else
        m_ins = '0;
      m_done = 0;
      m_wait = m_ins.valid && (m_ins.re || m_ins.mwe) && !misal(m_ins);
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    check("stall", 32'(mem_stall), 32'(m_wait));
    check("req", 32'(dmem_req), 32'(m_wait));
    check("dmem_we", 32'(dmem_we), 32'(m_ins.mwe));
    check("wstrb", 32'(dmem_wstrb), 32'(m_ins.mwe ? strobe(m_ins) : 4'b0000));
    check("misalign", 32'(mem_misalign), 32'(misal(m_ins)));
    check("we_mem", 32'(rf_we_mem), 32'(exp_we_mem()));
    check("we_wb", 32'(rf_we_wb), 32'(m_wb_we));
    if (m_wait) begin
      check("addr", dmem_addr, m_ins.alu & ~32'h3);
      check("wdata", dmem_wdata, lanes(m_ins));
    end
    if (exp_we_mem()) begin
      check("wa_mem", 32'(rf_wa_mem), 32'(m_ins.wa));
      check("wd_mem", rf_wd_mem, exp_wd_mem());
    end
    if (m_wb_we) begin
      check("wa_wb", 32'(rf_wa_wb), 32'(m_wb_wa));
      check("wd_wb", rf_wd_wb, m_wb_wd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] wa, input logic [31:0] alu,
                       input logic re, input logic mwe, input logic [1:0] size, input logic sext,
                       input logic [31:0] wd);
    ex_valid = v; ex_rf_we = we; ex_rf_wa = wa; ex_alu_res = alu;
    ex_mem_re = re; ex_mem_we = mwe; ex_mem_size = size; ex_mem_sext = sext; ex_mem_wd = wd;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0);
  endtask

  int stall_cnt;

  initial begin
    rstn = 1'b0;
    bubble();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    step(); step();
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_we_mem", 32'(rf_we_mem), 32'd0);
    check("rst_wd_mem", rf_wd_mem, 32'd0);
    check("rst_we_wb", 32'(rf_we_wb), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    rstn = 1'b1;
    step();

    // ALU op to r5
    drive(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0);
    step(); bubble(); #1;
    check("alu_we_mem", 32'(rf_we_mem), 32'd1);
    check("alu_wa_mem", 32'(rf_wa_mem), 32'd5);
    check("alu_wd_mem", rf_wd_mem, 32'h1234);
    step(); #1;
    check("alu_we_wb", 32'(rf_we_wb), 32'd1);
    check("alu_wa_wb", 32'(rf_wa_wb), 32'd5);
    check("alu_wd_wb", rf_wd_wb, 32'h1234);

    // LB 0x103 sign-extended, ack on third WAIT cycle
    drive(1'b1, 1'b1, 5'd7, 32'h103, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0);
    step(); bubble();
    stall_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      dmem_ack = (c == 3);
      dmem_rdata = (c == 3) ? 32'h80FF_FF00 : 32'd0;
      #1;
      if (mem_stall) stall_cnt++;
      check("lb_we_wait", 32'(rf_we_mem), 32'd0);
      step();
    end
    dmem_ack = 1'b0; #1;
    check("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    check("lb_stall_done", 32'(mem_stall), 32'd0);
    check("lb_we_done", 32'(rf_we_mem), 32'd1);
    check("lb_wd_done", rf_wd_mem, 32'hFFFF_FF80);
    step(); #1;
    check("lb_wd_wb", rf_wd_wb, 32'hFFFF_FF80);

    // SH 0x102 followed back-to-back by LW 0x200
    drive(1'b1, 1'b0, 5'd0, 32'h102, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD);
    step();
    drive(1'b1, 1'b1, 5'd9, 32'h200, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    #1;
    check("sh_req", 32'(dmem_req), 32'd1);
    check("sh_we", 32'(dmem_we), 32'd1);
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("sh_addr", dmem_addr, 32'h100);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0; #1;
    check("sh_we_mem", 32'(rf_we_mem), 32'd0);
    check("sh_req_done", 32'(dmem_req), 32'd0);
    step(); bubble(); #1;
    check("b2b_req", 32'(dmem_req), 32'd1);
    check("b2b_addr", dmem_addr, 32'h200);
    check("b2b_we", 32'(dmem_we), 32'd0);
    check("sh_we_wb", 32'(rf_we_wb), 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0; #1;
    check("lw_we_mem", 32'(rf_we_mem), 32'd1);
    check("lw_wd_mem", rf_wd_mem, 32'hDEAD_BEEF);

    // LHU 0x102 zero-extended, ack on second WAIT cycle
    drive(1'b1, 1'b1, 5'd10, 32'h102, 1'b1, 1'b0, 2'b01, 1'b0, 32'd0);
    step(); bubble();
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h8765_4321;
    step();
    dmem_ack = 1'b0; #1;
    check("lhu_wd_mem", rf_wd_mem, 32'h0000_8765);

    // LH 0x100 sign-extended, ack on first WAIT cycle
    drive(1'b1, 1'b1, 5'd11, 32'h100, 1'b1, 1'b0, 2'b01, 1'b1, 32'd0);
    step(); bubble();
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_F00F;
    step();
    dmem_ack = 1'b0; #1;
    check("lh_wd_mem", rf_wd_mem, 32'hFFFF_F00F);
    step();

    // misaligned LW 0x101
    drive(1'b1, 1'b1, 5'd12, 32'h101, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    step(); bubble(); #1;
    check("mis_flag", 32'(mem_misalign), 32'd1);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(mem_stall), 32'd0);
    check("mis_we_mem", 32'(rf_we_mem), 32'd0);
    step(); #1;
    check("mis_clear", 32'(mem_misalign), 32'd0);
    check("mis_we_wb", 32'(rf_we_wb), 32'd0);

    // ALU op targeting r0
    drive(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0);
    step(); bubble(); #1;
    check("r0_we_mem", 32'(rf_we_mem), 32'd0);
    step(); #1;
    check("r0_we_wb", 32'(rf_we_wb), 32'd0);

    // reset asserted during WAIT, late ack after release
    drive(1'b1, 1'b1, 5'd13, 32'h40, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0);
    step(); bubble(); #1;
    check("rw_req_before", 32'(dmem_req), 32'd1);
    rstn = 1'b0; #1;
    check("rw_req_async", 32'(dmem_req), 32'd0);
    check("rw_stall_async", 32'(mem_stall), 32'd0);
    step(); step();
    rstn = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step(); #1;
    check("rw_req_after", 32'(dmem_req), 32'd0);
    check("rw_we_mem", 32'(rf_we_mem), 32'd0);
    check("rw_wd_mem", rf_wd_mem, 32'd0);
    check("rw_we_wb", 32'(rf_we_wb), 32'd0);
    dmem_ack = 1'b0;
    step(); #1;
    check("rw_wd_wb", rf_wd_wb, 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
